// File: rtl/hit_event_buffer.sv
// hit_event_buffer
// Collects asynchronous hits into a latch, declares an event when enough
// detector layers fire inside a time window, and stores {timestamp, hits} in a
// small FIFO. A mode-0 SPI slave port drains the FIFO one frame per chip
// select; a frame is popped only once every one of its bits has been shifted out.
module hit_event_buffer #(
    parameter int N_CH       = 24,
    parameter int GROUP      = 2,
    parameter int MIN_LAYERS = 12,
    parameter int WINDOW     = 64,
    parameter int DEAD_CYC   = 32,
    parameter int DEPTH      = 8,
    parameter int TS_W       = 16
) (
    input  logic                   sys_clk_pll,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        S,
    input  logic                   spi_cs,
    input  logic                   spi_clk,
    output logic                   spi_miso,
    output logic                   trigger,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int L   = N_CH / GROUP;
    localparam int F   = 2 + TS_W + N_CH;
    localparam int EW  = TS_W + N_CH;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int NLW = $clog2(L + 1);
    localparam int BW  = $clog2(F + 1);
    localparam int WW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int DW  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [NLW-1:0] MIN_L     = NLW'(MIN_LAYERS);
    localparam logic [WW-1:0]  WIN_INIT  = WW'(WINDOW - 1);
    localparam logic [DW-1:0]  DEAD_INIT = DW'(DEAD_CYC - 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(F - 1);
    localparam logic [BW-1:0]  BIT_FULL  = BW'(F);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DEAD    = 2'd2
    } state_t;

    // Synchronizer stages and edge-detect history
    logic [N_CH-1:0] s_meta, s_sync;
    logic            cs_meta, cs_sync, cs_q;
    logic            sclk_meta, sclk_sync, sclk_q;

    // Timestamp, hit latch and FSM
    logic [TS_W-1:0] ts;
    logic [N_CH-1:0] h, h_next;
    logic [NLW-1:0]  nlayers;
    logic            coinc;
    state_t          state, state_next;
    logic [WW-1:0]   win_cnt, win_next;
    logic [DW-1:0]   dead_cnt, dead_next;
    logic            commit;

    // Pending commit (written into the FIFO one cycle after the decision)
    logic            push_pend;
    logic [EW-1:0]   push_data;

    // Event FIFO
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push_ok, drop, pop;
    logic [EW-1:0]   head;

    // SPI side
    logic [F-1:0]    shreg;
    logic [BW-1:0]   bit_cnt;
    logic            frame_valid, frame_ovf;
    logic            cs_fall, cs_rise, sclk_fall;

    // Bring every asynchronous input into the sys_clk_pll domain.
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what a real
    // two-stage synchronizer chain needs.
    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            s_meta    <= '0;
            s_sync    <= '0;
            cs_meta   <= 1'b0;
            cs_sync   <= 1'b0;
            cs_q      <= 1'b0;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_q    <= 1'b0;
        end else begin
            s_meta    <= S;
            s_sync    <= s_meta;
            cs_meta   <= spi_cs;
            cs_sync   <= cs_meta;
            cs_q      <= cs_sync;
            sclk_meta <= spi_clk;
            sclk_sync <= sclk_meta;
            sclk_q    <= sclk_sync;
        end
    end

    // Free-running timestamp; wraps naturally at all-ones.
    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    // Count layers with at least one latched hit.
    always_comb begin
        nlayers = '0;
        for (int k = 0; k < L; k++) begin
            nlayers = nlayers + NLW'(|h[k*GROUP +: GROUP]);
        end
        coinc = (nlayers >= MIN_L);
    end

    // Next-state logic: accumulate hits, commit on coincidence, reject noise.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        win_next   = win_cnt;
        dead_next  = dead_cnt;
        h_next     = h;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                h_next = h | s_sync;
                if (|s_sync) begin
                    state_next = COLLECT;
                    win_next   = WIN_INIT;
                end
            end
            COLLECT: begin
                if (coinc) begin
                    commit     = 1'b1;
                    h_next     = '0;
                    dead_next  = DEAD_INIT;
                    state_next = DEAD;
                end else if (win_cnt == '0) begin
                    h_next     = '0;
                    state_next = IDLE;
                end else begin
                    h_next   = h | s_sync;
                    win_next = win_cnt - 1'b1;
                end
            end
            DEAD: begin
                h_next = '0;
                if (dead_cnt == '0) state_next = IDLE;
                else                dead_next  = dead_cnt - 1'b1;
            end
            default: begin
                h_next     = '0;
                state_next = IDLE;
            end
        endcase
    end

    // FSM registers plus the one-cycle commit staging register.
    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_cnt   <= '0;
            dead_cnt  <= '0;
            h         <= '0;
            push_pend <= 1'b0;
            push_data <= '0;
        end else begin
            state     <= state_next;
            win_cnt   <= win_next;
            dead_cnt  <= dead_next;
            h         <= h_next;
            push_pend <= commit;
            if (commit) push_data <= {ts, h};
        end
    end

    // A commit that finds the FIFO full is dropped, even if a pop lands in
    // the same cycle; otherwise push and pop proceed together.
    assign drop    = push_pend && (count == FULL_CNT);
    assign push_ok = push_pend && !drop;
    assign head    = mem[rd_ptr];

    // FIFO storage.
    // NOTE: the data array has no reset; the pointers and count define which
    // entries are meaningful, so clearing the RAM would only cost area.
    always_ff @(posedge sys_clk_pll) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; cleared only once a frame reporting it has been read.
    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n)                 overflow <= 1'b0;
        else if (drop)              overflow <= 1'b1;
        else if (pop && frame_ovf)  overflow <= 1'b0;
    end

    assign cs_fall   = cs_q && !cs_sync;
    assign cs_rise   = !cs_q && cs_sync;
    assign sclk_fall = sclk_q && !sclk_sync && !cs_sync;
    assign pop       = cs_rise && frame_valid && (bit_cnt >= BIT_LAST);

    // SPI shift register: load on CS fall, shift on each spi_clk fall.
    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_ovf   <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt <= '0;
            if (count != '0) begin
                shreg       <= {1'b1, overflow, head};
                frame_valid <= 1'b1;
                frame_ovf   <= overflow;
            end else begin
                shreg       <= '0;
                frame_valid <= 1'b0;
                frame_ovf   <= 1'b0;
            end
        end else if (sclk_fall) begin
            shreg <= {shreg[F-2:0], 1'b0};
            if (bit_cnt != BIT_FULL) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Trigger follows the stored-event count with one cycle of latency.
    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n) trigger <= 1'b0;
        else        trigger <= (count != '0);
    end

    assign spi_miso   = !cs_sync && shreg[F-1];
    assign fifo_count = count;

endmodule

// File: tb/tb_hit_event_buffer.sv
// tb_hit_event_buffer: randomized and directed stimulus checked against a
// transaction-level reference model (event queue, deadline-based windows).
module tb_hit_event_buffer;

    localparam int N_CH       = 24;
    localparam int GROUP      = 2;
    localparam int L          = N_CH / GROUP;
    localparam int MIN_LAYERS = 12;
    localparam int WINDOW     = 64;
    localparam int DEAD_CYC   = 32;
    localparam int DEPTH      = 8;
    localparam int TS_W       = 16;
    localparam int F          = 2 + TS_W + N_CH;
    localparam int EW         = TS_W + N_CH;

    localparam int M_IDLE = 0;
    localparam int M_COLL = 1;
    localparam int M_DEAD = 2;

    logic                   sys_clk_pll = 1'b0;
    logic                   rst_n       = 1'b0;
    logic [N_CH-1:0]        s           = '0;
    logic                   spi_cs      = 1'b1;
    logic                   spi_clk     = 1'b0;
    logic                   spi_miso;
    logic                   trigger;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;

    always #5 sys_clk_pll = ~sys_clk_pll;

    hit_event_buffer #(
        .N_CH(N_CH), .GROUP(GROUP), .MIN_LAYERS(MIN_LAYERS), .WINDOW(WINDOW),
        .DEAD_CYC(DEAD_CYC), .DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .sys_clk_pll(sys_clk_pll),
        .rst_n      (rst_n),
        .S          (s),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_miso   (spi_miso),
        .trigger    (trigger),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_k;
    int              m_state;
    logic [N_CH-1:0] m_h;
    int              m_win_end, m_dead_end;
    bit              m_pend;
    logic [EW-1:0]   m_pend_data;
    logic [EW-1:0]   m_q[$];
    bit              m_ovf, m_trig;
    logic [N_CH-1:0] s_p1, s_p2;
    bit              cs_p1, cs_p2, cs_p3, sc_p1, sc_p2, sc_p3;
    logic [F-1:0]    m_frame;
    bit              m_fvalid, m_fovf;
    int              m_bits;

    function automatic void model_reset();
        m_k = 0; m_state = M_IDLE; m_h = '0; m_win_end = 0; m_dead_end = 0;
        m_pend = 1'b0; m_pend_data = '0; m_q.delete(); m_ovf = 1'b0; m_trig = 1'b0;
        s_p1 = '0; s_p2 = '0;
        cs_p1 = 1'b0; cs_p2 = 1'b0; cs_p3 = 1'b0;
        sc_p1 = 1'b0; sc_p2 = 1'b0; sc_p3 = 1'b0;
        m_frame = '0; m_fvalid = 1'b0; m_fovf = 1'b0; m_bits = 0;
    endfunction

    function automatic int layers_hit(input logic [N_CH-1:0] hv);
        int n = 0;
        for (int l = 0; l < L; l++) if (hv[l*GROUP +: GROUP] != '0) n++;
        return n;
    endfunction

    // One clock edge of the model; inputs seen through a two-cycle delay.
    function automatic void model_step();
        bit              cs_s, cs_q, sc_s, sc_q, do_pop, drop;
        int              pre_n;
        logic [N_CH-1:0] sv;
        logic [TS_W-1:0] tsv;
        m_k++;
        cs_s = cs_p2; cs_q = cs_p3; sc_s = sc_p2; sc_q = sc_p3;
        sv    = s_p2;
        tsv   = TS_W'(m_k - 1);
        pre_n = m_q.size();
        m_trig = (pre_n != 0);

        do_pop = cs_s && !cs_q && m_fvalid && (m_bits >= F - 1);
        if (!cs_s && cs_q) begin
            m_bits   = 0;
            m_fvalid = (pre_n != 0);
            m_fovf   = m_fvalid && m_ovf;
            m_frame  = '0;
            if (m_fvalid) m_frame = {1'b1, m_ovf, m_q[0]};
        end else if (!cs_s && sc_q && !sc_s && m_bits < F) begin
            m_bits++;
        end

        drop = m_pend && (pre_n == DEPTH);
        if (do_pop) void'(m_q.pop_front());
        if (m_pend && !drop) m_q.push_back(m_pend_data);
        if (drop) m_ovf = 1'b1;
        else if (do_pop && m_fovf) m_ovf = 1'b0;
        m_pend = 1'b0;

        case (m_state)
            M_IDLE: begin
                m_h |= sv;
                if (sv != '0) begin
                    m_state   = M_COLL;
                    m_win_end = m_k + WINDOW;
                end
            end
            M_COLL: begin
                if (layers_hit(m_h) >= MIN_LAYERS) begin
                    m_pend      = 1'b1;
                    m_pend_data = {tsv, m_h};
                    m_h         = '0;
                    m_dead_end  = m_k + DEAD_CYC;
                    m_state     = M_DEAD;
                end else if (m_k == m_win_end) begin
                    m_h     = '0;
                    m_state = M_IDLE;
                end else begin
                    m_h |= sv;
                end
            end
            default: if (m_k == m_dead_end) m_state = M_IDLE;
        endcase

        s_p2  = s_p1;  s_p1  = s;
        cs_p3 = cs_p2; cs_p2 = cs_p1; cs_p1 = spi_cs;
        sc_p3 = sc_p2; sc_p2 = sc_p1; sc_p1 = spi_clk;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk_pll);
        model_step();
        @(negedge sys_clk_pll);
        check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("trigger", 64'(trigger), 64'(m_trig));
        if (cs_p2) check("miso_idle", 64'(spi_miso), 64'd0);
    endtask

    function automatic logic [N_CH-1:0] layer_expand(input logic [L-1:0] sel);
        logic [N_CH-1:0] r = '0;
        for (int l = 0; l < L; l++) if (sel[l]) r[l*GROUP +: GROUP] = '1;
        return r;
    endfunction

    function automatic logic [N_CH-1:0] gen_full();
        logic [N_CH-1:0] r = '0;
        for (int l = 0; l < L; l++)
            r[l*GROUP +: GROUP] = GROUP'($urandom_range(1, (1 << GROUP) - 1));
        return r;
    endfunction

    task automatic pulse(input logic [N_CH-1:0] pat, input int len, input int gap);
        s = pat;
        repeat (len) tick();
        s = '0;
        repeat (gap) tick();
    endtask

    // Present nbits bits of one frame; optionally land a coincidence push on
    // the same edge as the CS-rise pop.
    task automatic read_frame(input int nbits, input bit coinc, output logic [F-1:0] got);
        logic [F-1:0] ones = '1;
        logic [F-1:0] mask;
        got = '0;
        spi_cs = 1'b0;
        repeat (6) tick();
        got[F-1] = spi_miso;
        for (int i = 1; i < nbits; i++) begin
            spi_clk = 1'b1;
            repeat (6) tick();
            spi_clk = 1'b0;
            repeat (6) tick();
            got[F-1-i] = spi_miso;
        end
        mask = ~(ones >> nbits);
        check("frame_bits", 64'(got & mask), 64'(m_frame & mask));
        if (coinc) begin
            s = '1;
            tick();
            s = '0;
            tick();
        end
        spi_cs = 1'b1;
        repeat (6) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [F-1:0]    got, got2;
        logic [N_CH-1:0] pats[9];
        logic [N_CH-1:0] full;
        logic [F-1:0]    ones;
        int              k0;

        ones = '1;
        model_reset();
        repeat (3) @(negedge sys_clk_pll);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_trigger", 64'(trigger), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_miso", 64'(spi_miso), 64'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Single-cycle coincidence on every layer
        k0 = m_k;
        pulse(24'h555555, 1, 40);
        check("s1_count", 64'(fifo_count), 64'd1);
        check("s1_trigger", 64'(trigger), 64'd1);
        read_frame(F, 1'b0, got);
        check("s1_valid", 64'(got[F-1]), 64'd1);
        check("s1_hits", 64'(got[N_CH-1:0]), 64'h555555);
        check("s1_ts", 64'(got[N_CH +: TS_W]), 64'(k0 + 3));
        check("s1_count_after", 64'(fifo_count), 64'd0);
        check("s1_trigger_after", 64'(trigger), 64'd0);

        // Noise rejected, latch cleared before the next partial hit set
        pulse(24'h000003, 1, 70);
        pulse(24'hFFFFFC, 1, 70);
        check("noise_count", 64'(fifo_count), 64'd0);

        // Nine events with no reads: eight stored, one dropped
        for (int i = 0; i < 9; i++) begin
            pats[i] = gen_full();
            pulse(pats[i], 1, 40);
        end
        check("ovf_count", 64'(fifo_count), 64'd8);
        check("ovf_set", 64'(overflow), 64'd1);
        for (int j = 0; j < 8; j++) begin
            read_frame(F, 1'b0, got);
            check("ovf_hits", 64'(got[N_CH-1:0]), 64'(pats[j]));
            if (j == 0) begin
                check("ovf_bit", 64'(got[F-2]), 64'd1);
                check("ovf_cleared", 64'(overflow), 64'd0);
            end
        end
        check("ovf_drained", 64'(fifo_count), 64'd0);

        // Aborted read does not pop; the next full read returns the same frame
        pulse(gen_full(), 1, 40);
        read_frame(10, 1'b0, got);
        check("abort_count", 64'(fifo_count), 64'd1);
        read_frame(F, 1'b0, got2);
        check("reread_prefix", 64'(got2 & ~(ones >> 10)), 64'(got));
        check("reread_count", 64'(fifo_count), 64'd0);

        // Push and pop on the same edge
        for (int i = 0; i < 3; i++) pulse(gen_full(), 1, 40);
        check("pp_before", 64'(fifo_count), 64'd3);
        read_frame(F, 1'b1, got);
        check("pp_after", 64'(fifo_count), 64'd3);

        // Reset in the middle of an SPI frame
        spi_cs = 1'b0;
        repeat (6) tick();
        spi_clk = 1'b1;
        repeat (3) tick();
        rst_n   = 1'b0;
        spi_cs  = 1'b1;
        spi_clk = 1'b0;
        model_reset();
        #1;
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_trigger", 64'(trigger), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_miso", 64'(spi_miso), 64'd0);
        @(negedge sys_clk_pll);
        @(negedge sys_clk_pll);
        rst_n = 1'b1;
        repeat (4) tick();
        pulse(gen_full(), 1, 40);
        read_frame(F, 1'b0, got);
        check("post_rst_valid", 64'(got[F-1]), 64'd1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: pulse(gen_full(), $urandom_range(1, 3), $urandom_range(0, 40));
                1: begin
                    logic [N_CH-1:0] sub;
                    full = gen_full();
                    sub  = layer_expand(L'($urandom));
                    pulse(full & sub, 1, $urandom_range(0, 90));
                    pulse(full & ~sub, 1, $urandom_range(0, 40));
                end
                2: begin
                    full = gen_full();
                    full[$urandom_range(0, L - 1)*GROUP +: GROUP] = '0;
                    pulse(full, $urandom_range(1, 3), $urandom_range(0, 40));
                end
                default: read_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, F - 1) : F,
                                    1'b0, got);
            endcase
            repeat ($urandom_range(0, 50)) tick();
        end

        // Drain whatever is left
        for (int j = 0; j < DEPTH + 1; j++) begin
            if (fifo_count != 0) read_frame(F, 1'b0, got);
        end
        repeat (10) tick();
        check("final_count", 64'(fifo_count), 64'(m_q.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
